// File: rtl/redmule_z_buffer_scheduler_pkg.sv
// Shared types for the Z/Y buffer scheduler: scheduler state and the buffer
// control/flag bundles it drives and consumes.
package redmule_z_buffer_scheduler_pkg;

  localparam int unsigned ARRAY_WIDTH  = 4;
  localparam int unsigned ARRAY_HEIGHT = 8;

  typedef enum logic [2:0] {
    Z_IDLE  = 3'd0,
    Z_CLEAR = 3'd1,
    Z_LOAD  = 3'd2,
    Z_PUSH  = 3'd3,
    Z_FILL  = 3'd4,
    Z_STORE = 3'd5,
    Z_DONE  = 3'd6
  } z_sched_state_e;

  typedef struct packed {
    logic [$clog2(ARRAY_HEIGHT):0] cols_lftovr;
    logic [$clog2(ARRAY_WIDTH):0]  rows_lftovr;
    logic                          load;
    logic                          y_valid;
    logic                          y_push_enable;
    logic                          fill;
    logic                          store;
    logic                          ready;
    logic                          buffer_clk_en;
  } z_buffer_ctrl_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic loaded;
    logic y_pushed;
  } z_buffer_flgs_t;

endpackage

// File: rtl/redmule_z_buffer_scheduler.sv
// Walks one Z/Y buffer through CLEAR, optional Y load/push, engine fill and
// Z store for every tile of a job; sole driver of the buffer controls.
module redmule_z_buffer_scheduler
  import redmule_z_buffer_scheduler_pkg::*;
#(
  parameter int unsigned W      = ARRAY_WIDTH,
  parameter int unsigned D      = ARRAY_HEIGHT,
  parameter int unsigned TILE_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [TILE_W-1:0]    n_tiles_i,
  input  logic                 y_bias_i,
  input  logic [$clog2(W):0]   rows_lftovr_i,
  input  logic [$clog2(D):0]   cols_lftovr_i,
  input  logic                 y_valid_i,
  output logic                 y_ready_o,
  input  logic                 eng_valid_i,
  input  logic                 eng_en_i,
  output logic                 z_valid_o,
  input  logic                 z_ready_i,
  input  z_buffer_flgs_t       flags_i,
  output z_buffer_ctrl_t       ctrl_o,
  output logic                 clear_o,
  output logic                 reg_enable_o,
  output logic                 busy_o,
  output logic                 done_o
);

  z_sched_state_e      state_q, state_d;
  logic [TILE_W-1:0]   tile_cnt_q, tile_cnt_d;
  logic [TILE_W-1:0]   last_tile_q, last_tile_d;
  logic                y_bias_q, y_bias_d;
  logic [$clog2(W):0]  rows_q, rows_d;
  logic [$clog2(D):0]  cols_q, cols_d;
  logic                is_last_s;

  // State, tile counter and job configuration registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= Z_IDLE;
      tile_cnt_q  <= '0;
      last_tile_q <= '0;
      y_bias_q    <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
    end else begin
      state_q     <= state_d;
      tile_cnt_q  <= tile_cnt_d;
      last_tile_q <= last_tile_d;
      y_bias_q    <= y_bias_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
    end
  end

  // Next-state decode and buffer control outputs.
  always_comb begin
    state_d      = state_q;
    tile_cnt_d   = tile_cnt_q;
    last_tile_d  = last_tile_q;
    y_bias_d     = y_bias_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    ctrl_o       = '0;
    clear_o      = 1'b0;
    reg_enable_o = 1'b0;
    y_ready_o    = 1'b0;
    z_valid_o    = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != Z_IDLE);
    is_last_s    = (tile_cnt_q == last_tile_q);

    // Leftover geometry only applies to the final tile; earlier tiles are full.
    if (state_q != Z_IDLE) begin
      ctrl_o.buffer_clk_en = 1'b1;
      if (is_last_s) begin
        ctrl_o.rows_lftovr = rows_q;
        ctrl_o.cols_lftovr = cols_q;
      end else begin
        ctrl_o.rows_lftovr = '0;
        ctrl_o.cols_lftovr = '0;
      end
    end else begin
      ctrl_o.buffer_clk_en = 1'b0;
    end

    case (state_q)
      Z_IDLE: begin
        if (start_i) begin
          state_d     = Z_CLEAR;
          tile_cnt_d  = '0;
          last_tile_d = (n_tiles_i == '0) ? '0 : n_tiles_i - TILE_W'(1);
          y_bias_d    = y_bias_i;
          rows_d      = rows_lftovr_i;
          cols_d      = cols_lftovr_i;
        end else begin
          state_d = Z_IDLE;
        end
      end
      Z_CLEAR: begin
        clear_o = 1'b1;
        state_d = y_bias_q ? Z_LOAD : Z_FILL;
      end
      Z_LOAD: begin
        ctrl_o.load    = 1'b1;
        ctrl_o.y_valid = y_valid_i;
        y_ready_o      = 1'b1;
        if (flags_i.loaded) begin
          state_d = Z_PUSH;
        end else begin
          state_d = Z_LOAD;
        end
      end
      Z_PUSH: begin
        ctrl_o.y_push_enable = 1'b1;
        reg_enable_o         = eng_en_i;
        if (flags_i.y_pushed) begin
          state_d = Z_FILL;
        end else begin
          state_d = Z_PUSH;
        end
      end
      Z_FILL: begin
        ctrl_o.fill  = eng_valid_i;
        reg_enable_o = eng_valid_i;
        if (flags_i.full) begin
          state_d = Z_STORE;
        end else begin
          state_d = Z_FILL;
        end
      end
      Z_STORE: begin
        z_valid_o    = 1'b1;
        ctrl_o.store = z_ready_i;
        ctrl_o.ready = z_ready_i;
        if (flags_i.empty) begin
          tile_cnt_d = tile_cnt_q + TILE_W'(1);
          state_d    = is_last_s ? Z_DONE : Z_CLEAR;
        end else begin
          state_d = Z_STORE;
        end
      end
      Z_DONE: begin
        done_o  = 1'b1;
        state_d = Z_IDLE;
      end
      default: begin
        state_d = Z_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_redmule_z_buffer_scheduler.sv
// Directed bench for the Z buffer scheduler with a small behavioural buffer
// model (W=4, D=8) producing the loaded/pushed/full/empty flags.
module tb_redmule_z_buffer_scheduler;
  import redmule_z_buffer_scheduler_pkg::*;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int TW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [TW-1:0]    n_tiles_i;
  logic             y_bias_i;
  logic [2:0]       rows_lftovr_i;
  logic [3:0]       cols_lftovr_i;
  logic             y_valid_i, y_ready_o, eng_valid_i, eng_en_i;
  logic             z_valid_o, z_ready_i;
  z_buffer_flgs_t   flags;
  z_buffer_ctrl_t   ctrl_o;
  logic             clear_o, reg_enable_o, busy_o, done_o;

  always #5 clk = ~clk;

  redmule_z_buffer_scheduler #(.W(W), .D(D), .TILE_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .n_tiles_i(n_tiles_i),
    .y_bias_i(y_bias_i), .rows_lftovr_i(rows_lftovr_i), .cols_lftovr_i(cols_lftovr_i),
    .y_valid_i(y_valid_i), .y_ready_o(y_ready_o), .eng_valid_i(eng_valid_i),
    .eng_en_i(eng_en_i), .z_valid_o(z_valid_o), .z_ready_i(z_ready_i),
    .flags_i(flags), .ctrl_o(ctrl_o), .clear_o(clear_o),
    .reg_enable_o(reg_enable_o), .busy_o(busy_o), .done_o(done_o)
  );

  // Buffer model: each flag rises together with the beat that completes its phase.
  int ld_cnt, ps_cnt, fl_cnt, st_cnt;
  always_comb begin
    flags          = '0;
    flags.loaded   = ctrl_o.load && ctrl_o.y_valid && (ld_cnt == W - 1);
    flags.y_pushed = ctrl_o.y_push_enable && reg_enable_o && (ps_cnt == D - 1);
    flags.full     = ctrl_o.fill && (fl_cnt == D - 1);
    flags.empty    = ctrl_o.store && (st_cnt == W - 1);
  end

  always @(posedge clk or posedge rst) begin
    if (rst || clear_o) begin
      ld_cnt <= 0; ps_cnt <= 0; fl_cnt <= 0; st_cnt <= 0;
    end else begin
      if (ctrl_o.load && ctrl_o.y_valid) ld_cnt <= (ld_cnt == W - 1) ? 0 : ld_cnt + 1;
      if (ctrl_o.y_push_enable && reg_enable_o) ps_cnt <= (ps_cnt == D - 1) ? 0 : ps_cnt + 1;
      if (ctrl_o.fill) fl_cnt <= (fl_cnt == D - 1) ? 0 : fl_cnt + 1;
      if (ctrl_o.store) st_cnt <= (st_cnt == W - 1) ? 0 : st_cnt + 1;
    end
  end

  // Event monitor; leftover fields must be nonzero only during the last tile.
  int n_load, n_yrdy, n_push, n_fill, n_store, n_clear, n_done, n_busy, n_lft, lft_bad;
  int cur_tiles, cur_rows, cur_cols;
  always @(negedge clk) begin
    int clr_now, er, ec;
    if (!rst) begin
      clr_now = n_clear + (clear_o ? 1 : 0);
      er = (clr_now == cur_tiles) ? cur_rows : 0;
      ec = (clr_now == cur_tiles) ? cur_cols : 0;
      if (ctrl_o.load && ctrl_o.y_valid) n_load <= n_load + 1;
      if (y_ready_o) n_yrdy <= n_yrdy + 1;
      if (ctrl_o.y_push_enable && reg_enable_o) n_push <= n_push + 1;
      if (ctrl_o.fill) n_fill <= n_fill + 1;
      if (ctrl_o.store) n_store <= n_store + 1;
      if (clear_o) n_clear <= n_clear + 1;
      if (done_o) n_done <= n_done + 1;
      if (busy_o) n_busy <= n_busy + 1;
      if (ctrl_o.rows_lftovr != 3'd0 || ctrl_o.cols_lftovr != 4'd0) n_lft <= n_lft + 1;
      if (ctrl_o.buffer_clk_en && !done_o &&
          (int'(ctrl_o.rows_lftovr) != er || int'(ctrl_o.cols_lftovr) != ec))
        lft_bad <= lft_bad + 1;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int n, yb, r, c, mid;
    int e_load, e_yrdy, e_push, e_fill, e_store, e_clear, e_done, e_busy, e_lft;
  } vec_t;
  vec_t vecs[5];

  task automatic start_job(input int n, input int yb, input int r, input int c);
    @(posedge clk); #2;
    n_load = 0; n_yrdy = 0; n_push = 0; n_fill = 0; n_store = 0;
    n_clear = 0; n_done = 0; n_busy = 0; n_lft = 0; lft_bad = 0;
    cur_tiles = (n == 0) ? 1 : n; cur_rows = r; cur_cols = c;
    n_tiles_i = TW'(n); y_bias_i = (yb != 0); rows_lftovr_i = 3'(r); cols_lftovr_i = 4'(c);
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (n_done == 0 && cyc < 400) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk({name, "_timeout"}, int'(cyc < 400), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    y_valid_i = 1'b1; eng_en_i = 1'b1; eng_valid_i = 1'b1; z_ready_i = 1'b1;
    start_job(v.n, v.yb, v.r, v.c);
    cyc = 0;
    while (n_done == 0 && cyc < 400) begin
      @(posedge clk); #2;
      cyc++;
      start_i = (v.mid != 0 && cyc == 10);
    end
    start_i = 1'b0;
    chk({name, "_timeout"}, int'(cyc < 400), 1);
    repeat (3) @(posedge clk);
    #2;
    chk({name, "_load"},  n_load,  v.e_load);
    chk({name, "_yrdy"},  n_yrdy,  v.e_yrdy);
    chk({name, "_push"},  n_push,  v.e_push);
    chk({name, "_fill"},  n_fill,  v.e_fill);
    chk({name, "_store"}, n_store, v.e_store);
    chk({name, "_clear"}, n_clear, v.e_clear);
    chk({name, "_done"},  n_done,  v.e_done);
    chk({name, "_busy"},  n_busy,  v.e_busy);
    chk({name, "_lft"},   n_lft,   v.e_lft);
    chk({name, "_lftbad"}, lft_bad, 0);
    chk({name, "_idle"},  int'(busy_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit pat_z[7];
    bit pat_e[5];
    int i, k;
    bit left;

    //           n  yb r  c  mid load yrdy push fill store clr done busy lft
    vecs[0] = '{1, 1, 0, 0, 0,  4,   4,   8,   8,   4,   1,  1,  26,  0};
    vecs[1] = '{2, 0, 3, 0, 0,  0,   0,   0,  16,   8,   2,  1,  27, 13};
    vecs[2] = '{0, 0, 1, 3, 0,  0,   0,   0,   8,   4,   1,  1,  14, 13};
    vecs[3] = '{3, 1, 2, 5, 0, 12,  12,  24,  24,  12,   3,  1,  76, 25};
    vecs[4] = '{1, 1, 0, 0, 1,  4,   4,   8,   8,   4,   1,  1,  26,  0};
    pat_z = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pat_e = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; start_i = 1'b0; n_tiles_i = '0; y_bias_i = 1'b0;
    rows_lftovr_i = '0; cols_lftovr_i = '0;
    y_valid_i = 1'b1; eng_valid_i = 1'b1; eng_en_i = 1'b1; z_ready_i = 1'b1;
    cur_tiles = 1; cur_rows = 0; cur_cols = 0;
    #12;
    chk("rst_ctrl",   int'(ctrl_o), 0);
    chk("rst_busy",   int'(busy_o), 0);
    chk("rst_done",   int'(done_o), 0);
    chk("rst_clear",  int'(clear_o), 0);
    chk("rst_regen",  int'(reg_enable_o), 0);
    chk("rst_yready", int'(y_ready_o), 0);
    chk("rst_zvalid", int'(z_valid_o), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Store stalls: store/ready follow z_ready_i beat by beat.
    y_valid_i = 1'b1; eng_valid_i = 1'b1; z_ready_i = 1'b0;
    start_job(1, 0, 0, 0);
    k = 0;
    while (!z_valid_o && k < 50) begin
      @(posedge clk); #2;
      k++;
    end
    chk("zr_reach_store", int'(k < 50), 1);
    for (int j = 0; j < 7; j++) begin
      z_ready_i = pat_z[j];
      #1;
      chk($sformatf("zr_store%0d", j), int'(ctrl_o.store), int'(pat_z[j]));
      chk($sformatf("zr_ready%0d", j), int'(ctrl_o.ready), int'(pat_z[j]));
      @(posedge clk); #2;
    end
    chk("zr_done",   int'(done_o), 1);
    chk("zr_zvalid", int'(z_valid_o), 0);
    chk("zr_beats",  n_store, 4);
    z_ready_i = 1'b1;
    wait_done("zr");

    // Engine gaps: exactly eight valid beats fill the buffer.
    eng_valid_i = 1'b0;
    start_job(1, 0, 0, 0);
    chk("ev_clear", int'(clear_o), 1);
    @(posedge clk); #2;
    i = 0; left = 1'b0;
    while (!left && i < 40) begin
      eng_valid_i = pat_e[i % 5];
      #1;
      if (ctrl_o.fill != eng_valid_i || reg_enable_o != eng_valid_i)
        chk($sformatf("ev_fill%0d", i), int'(ctrl_o.fill), int'(eng_valid_i));
      @(posedge clk); #2;
      if (z_valid_o) left = 1'b1;
      else i++;
    end
    chk("ev_last_idx", i, 12);
    chk("ev_beats", n_fill, 8);
    eng_valid_i = 1'b1;
    wait_done("ev");
    chk("ev_no_extra", n_fill, 8);

    // Reset in the middle of FILL returns straight to idle.
    start_job(1, 0, 0, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("mr_in_fill", int'(ctrl_o.fill), 1);
    rst = 1'b1;
    #1;
    chk("mr_busy",  int'(busy_o), 0);
    chk("mr_ctrl",  int'(ctrl_o), 0);
    chk("mr_regen", int'(reg_enable_o), 0);
    chk("mr_clear", int'(clear_o), 0);
    @(posedge clk); #2;
    chk("mr_still_idle", int'(busy_o), 0);
    rst = 1'b0;
    run_vec(vecs[0], "mr_rerun");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
